// File: rtl/frame_align.sv
// frame_align: per-channel frame-clock word alignment controller.
//
// Each channel watches its deserialised frame-clock word. It issues
// one-cycle bitslip strobes to its ISERDES until the word equals PATTERN,
// then declares lock after LOCK_COUNT consecutive matches. LOSS_COUNT
// consecutive mismatches while locked restart alignment. A channel that has
// used MAX_SLIPS slips without locking parks in FAIL.
//
// Ports
//   sample_clk     single clock for all logic
//   reset_n        asynchronous active-low reset
//   enable         level; low forces every channel to IDLE
//   force_realign  [N_CH]        per-channel restart pulse
//   clk_data_out   [N_CH*WORD_W] frame word, channel c at [c*WORD_W +: WORD_W]
//   bitslip        [N_CH]        one-cycle bitslip strobe per channel
//   locked         [N_CH]        channel is in LOCKED
//   fail           [N_CH]        channel is in FAIL
//   slip_count     [N_CH*8]      slips since last restart, saturating
//   loss_count     [N_CH*8]      lock-loss events since reset, saturating

// One alignment channel. All outputs are registered and decoded from the
// next state, so nothing is combinational from the data word.
module frame_align_ch #(
    parameter int                WORD_W        = 8,
    parameter logic [WORD_W-1:0] PATTERN       = 'h0F,
    parameter int                SETTLE_CYCLES = 4,
    parameter int                LOCK_COUNT    = 16,
    parameter int                LOSS_COUNT    = 4,
    parameter int                MAX_SLIPS     = WORD_W
) (
    input  logic              sample_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              force_realign,
    input  logic [WORD_W-1:0] word,
    output logic              bitslip,
    output logic              locked,
    output logic              fail,
    output logic [7:0]        slip_count,
    output logic [7:0]        loss_count
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int HW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL} state_t;

    state_t          state, nxt;
    logic [MW-1:0]   match_cnt;
    logic [LW-1:0]   mis_cnt;
    // Loaded when a slip is issued and counts down to zero. It times the
    // SETTLE window and also blocks a new slip when a force_realign cut the
    // settle window short, so strobes stay SETTLE_CYCLES+1 apart.
    logic [HW-1:0]   holdoff;
    logic            match;
    logic            clr_slip, inc_slip, inc_loss;
    logic            clr_match, inc_match, clr_mis, inc_mis;

    always_comb begin
        nxt       = state;
        clr_slip  = 1'b0;
        inc_slip  = 1'b0;
        inc_loss  = 1'b0;
        clr_match = 1'b0;
        inc_match = 1'b0;
        clr_mis   = 1'b0;
        inc_mis   = 1'b0;
        match     = (word == PATTERN);
        if (!enable) begin
            nxt = IDLE;
        end else if (state == IDLE || force_realign) begin
            nxt       = CHECK;
            clr_slip  = 1'b1;
            clr_match = 1'b1;
            clr_mis   = 1'b1;
        end else begin
            case (state)
                CHECK: begin
                    if (match) begin
                        if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                            nxt       = LOCKED;
                            clr_match = 1'b1;
                            clr_mis   = 1'b1;
                        end else begin
                            inc_match = 1'b1;
                        end
                    end else begin
                        clr_match = 1'b1;
                        if (holdoff == '0) begin
                            nxt      = SLIP;
                            inc_slip = 1'b1;
                        end
                    end
                end
                SLIP:   nxt = SETTLE;
                SETTLE: begin
                    if (holdoff == '0)
                        nxt = (int'(slip_count) >= MAX_SLIPS) ? FAIL : CHECK;
                end
                LOCKED: begin
                    if (match) begin
                        clr_mis = 1'b1;
                    end else if (mis_cnt == LW'(LOSS_COUNT - 1)) begin
                        nxt       = CHECK;
                        inc_loss  = 1'b1;
                        clr_slip  = 1'b1;
                        clr_mis   = 1'b1;
                        clr_match = 1'b1;
                    end else begin
                        inc_mis = 1'b1;
                    end
                end
                FAIL:    nxt = FAIL;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            match_cnt  <= '0;
            mis_cnt    <= '0;
            holdoff    <= '0;
            slip_count <= '0;
            loss_count <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state   <= nxt;
            bitslip <= (nxt == SLIP);
            locked  <= (nxt == LOCKED);
            fail    <= (nxt == FAIL);

            if (inc_slip)
                holdoff <= HW'(SETTLE_CYCLES);
            else if (holdoff != '0)
                holdoff <= holdoff - 1'b1;

            if (clr_match)      match_cnt <= '0;
            else if (inc_match) match_cnt <= match_cnt + 1'b1;

            if (clr_mis)        mis_cnt <= '0;
            else if (inc_mis)   mis_cnt <= mis_cnt + 1'b1;

            if (clr_slip)
                slip_count <= '0;
            else if (inc_slip && slip_count != 8'hFF)
                slip_count <= slip_count + 1'b1;

            if (inc_loss && loss_count != 8'hFF)
                loss_count <= loss_count + 1'b1;
        end
    end
endmodule

module frame_align #(
    parameter int                N_CH          = 1,
    parameter int                WORD_W        = 8,
    parameter logic [WORD_W-1:0] PATTERN       = 'h0F,
    parameter int                SETTLE_CYCLES = 4,
    parameter int                LOCK_COUNT    = 16,
    parameter int                LOSS_COUNT    = 4,
    parameter int                MAX_SLIPS     = WORD_W
) (
    input  logic                     sample_clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [N_CH-1:0]          force_realign,
    input  logic [N_CH*WORD_W-1:0]   clk_data_out,
    output logic [N_CH-1:0]          bitslip,
    output logic [N_CH-1:0]          locked,
    output logic [N_CH-1:0]          fail,
    output logic [N_CH*8-1:0]        slip_count,
    output logic [N_CH*8-1:0]        loss_count
);
    // Assert asynchronously, release through two flops: channels see the
    // release after the second sample_clk edge, so nothing moves earlier.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        frame_align_ch #(
            .WORD_W        (WORD_W),
            .PATTERN       (PATTERN),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .LOCK_COUNT    (LOCK_COUNT),
            .LOSS_COUNT    (LOSS_COUNT),
            .MAX_SLIPS     (MAX_SLIPS)
        ) u_ch (
            .sample_clk    (sample_clk),
            .rst_n         (rst_n_int),
            .enable        (enable),
            .force_realign (force_realign[c]),
            .word          (clk_data_out[c*WORD_W +: WORD_W]),
            .bitslip       (bitslip[c]),
            .locked        (locked[c]),
            .fail          (fail[c]),
            .slip_count    (slip_count[c*8 +: 8]),
            .loss_count    (loss_count[c*8 +: 8])
        );
    end
endmodule

// File: tb/tb_frame_align.sv
// Scoreboard bench for frame_align with two channels and a rotating ISERDES
// model: each bitslip rotates that channel's word by one bit toward PATTERN.
module tb_frame_align;
    localparam int         NC     = 2;
    localparam int         SETTLE = 4;
    localparam logic [7:0] PAT    = 8'h0F;

    logic        sample_clk = 1'b0;
    logic        reset_n    = 1'b1;
    logic        enable     = 1'b0;
    logic [1:0]  force_realign = 2'b00;
    logic [15:0] clk_data_out;
    logic [1:0]  bitslip, locked, fail;
    logic [15:0] slip_count, loss_count;

    always #5 sample_clk = ~sample_clk;

    frame_align #(
        .N_CH(NC), .WORD_W(8), .PATTERN(PAT), .SETTLE_CYCLES(SETTLE),
        .LOCK_COUNT(16), .LOSS_COUNT(4), .MAX_SLIPS(8)
    ) dut (
        .sample_clk    (sample_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .force_realign (force_realign),
        .clk_data_out  (clk_data_out),
        .bitslip       (bitslip),
        .locked        (locked),
        .fail          (fail),
        .slip_count    (slip_count),
        .loss_count    (loss_count)
    );

    typedef enum int {EV_SLIP, EV_LOCK, EV_UNLOCK, EV_FAIL} kind_t;
    typedef struct {kind_t kind; int slips; int losses;} ev_t;

    ev_t  q0[$];
    ev_t  q1[$];
    int   passed = 0;
    int   total  = 0;

    // ISERDES model
    int   slip_seen [2] = '{0, 0};
    int   init_rot  [2] = '{0, 0};
    logic stuck     [2] = '{1'b0, 1'b0};
    logic bad       [2] = '{1'b0, 1'b0};

    function automatic logic [7:0] rol(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    always @(posedge sample_clk)
        for (int c = 0; c < NC; c++)
            if (bitslip[c] === 1'b1) slip_seen[c] <= slip_seen[c] + 1;

    always_comb begin
        clk_data_out = '0;
        for (int c = 0; c < NC; c++)
            if (!(stuck[c] || bad[c]))
                clk_data_out[c*8 +: 8] = rol(PAT, ((init_rot[c] - slip_seen[c]) % 8 + 8) % 8);
    end

    // Word for channel c will need k slips to reach PATTERN.
    task automatic set_off(input int c, input int k);
        init_rot[c] = (k + slip_seen[c]) % 8;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push(input int c, input kind_t k, input int s, input int l);
        ev_t e;
        e.kind = k; e.slips = s; e.losses = l;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic observe(input int c, input kind_t k);
        ev_t e;
        int  s, l;
        s = int'(slip_count[c*8 +: 8]);
        l = int'(loss_count[c*8 +: 8]);
        total++;
        if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
            $display("FAIL ch%0d event: unexpected %s slips=%0d losses=%0d", c, k.name(), s, l);
            return;
        end
        if (c == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.kind == k && e.slips == s && e.losses == l) passed++;
        else $display("FAIL ch%0d event: got %s slips=%0d losses=%0d, expected %s slips=%0d losses=%0d",
                      c, k.name(), s, l, e.kind.name(), e.slips, e.losses);
    endtask

    // Monitor: turns output edges into events and matches them to the queues.
    logic [1:0] locked_q = 2'b00;
    logic [1:0] fail_q   = 2'b00;
    int         cyc      = 0;
    int         last_slip [2] = '{-100, -100};

    always @(negedge sample_clk) begin
        cyc++;
        for (int c = 0; c < NC; c++) begin
            if (bitslip[c] === 1'b1) begin
                total++;
                if (cyc - last_slip[c] >= SETTLE + 1) passed++;
                else $display("FAIL ch%0d slip spacing: got %0d cycles, required >= %0d",
                              c, cyc - last_slip[c], SETTLE + 1);
                last_slip[c] = cyc;
                observe(c, EV_SLIP);
            end
            if (locked[c] === 1'b1 && !locked_q[c]) observe(c, EV_LOCK);
            if (locked[c] === 1'b0 &&  locked_q[c]) observe(c, EV_UNLOCK);
            if (fail[c] === 1'b1 && !fail_q[c])     observe(c, EV_FAIL);
        end
        locked_q = locked;
        fail_q   = fail;
    end

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge sample_clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        total++;
        if (q0.size() == 0 && q1.size() == 0) passed++;
        else $display("FAIL %s: timeout with ch0 %0d / ch1 %0d events pending, required 0",
                      name, q0.size(), q1.size());
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " bitslip"}, int'(bitslip), 0);
        chk({name, " locked"},  int'(locked),  0);
        chk({name, " fail"},    int'(fail),    0);
    endtask

    initial begin
        int found;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge sample_clk);
        #1;
        chk_quiet("reset");
        chk("reset slip_count", int'(slip_count), 0);
        chk("reset loss_count", int'(loss_count), 0);
        @(negedge sample_clk);
        reset_n = 1'b1;
        repeat (3) @(negedge sample_clk);

        // ch0 offset 3, ch1 already aligned
        set_off(0, 3); set_off(1, 0);
        for (int k = 1; k <= 3; k++) push(0, EV_SLIP, k, 0);
        push(0, EV_LOCK, 3, 0);
        push(1, EV_LOCK, 0, 0);
        enable = 1'b1;
        wait_drain("offset3 align", 400);
        @(negedge sample_clk); #1;
        chk("offset3 locked", int'(locked), 3);
        chk("offset3 slip_count0", int'(slip_count[7:0]), 3);

        // Independent realign: ch0 offset 1, ch1 offset 5
        push(0, EV_UNLOCK, 0, 0); push(1, EV_UNLOCK, 0, 0);
        push(0, EV_SLIP, 1, 0);   push(0, EV_LOCK, 1, 0);
        for (int k = 1; k <= 5; k++) push(1, EV_SLIP, k, 0);
        push(1, EV_LOCK, 5, 0);
        @(negedge sample_clk);
        set_off(0, 1); set_off(1, 5);
        force_realign = 2'b11;
        @(negedge sample_clk);
        force_realign = 2'b00;
        wait_drain("dual align", 600);
        @(negedge sample_clk); #1;
        chk("dual slip_count0", int'(slip_count[7:0]), 1);
        chk("dual slip_count1", int'(slip_count[15:8]), 5);

        // Three bad words keep lock
        @(negedge sample_clk);
        bad[0] = 1'b1;
        repeat (3) @(negedge sample_clk);
        bad[0] = 1'b0;
        repeat (20) @(negedge sample_clk); #1;
        chk("3bad locked0", int'(locked[0]), 1);
        chk("3bad loss_count0", int'(loss_count[7:0]), 0);

        // Four bad words drop lock, then relock
        push(0, EV_UNLOCK, 0, 1); push(0, EV_LOCK, 0, 1);
        @(negedge sample_clk);
        bad[0] = 1'b1;
        repeat (4) @(negedge sample_clk);
        bad[0] = 1'b0;
        wait_drain("4bad relock", 200);
        @(negedge sample_clk); #1;
        chk("4bad loss_count0", int'(loss_count[7:0]), 1);
        chk("4bad locked", int'(locked), 3);

        // Stuck word: lose lock, 8 slips, FAIL
        push(1, EV_UNLOCK, 0, 1);
        for (int k = 1; k <= 8; k++) push(1, EV_SLIP, k, 1);
        push(1, EV_FAIL, 8, 1);
        @(negedge sample_clk);
        stuck[1] = 1'b1;
        wait_drain("stuck fail", 600);
        repeat (20) @(negedge sample_clk); #1;
        chk("stuck fail1", int'(fail[1]), 1);
        chk("stuck bitslip1", int'(bitslip[1]), 0);
        chk("stuck slip_count1", int'(slip_count[15:8]), 8);
        push(1, EV_LOCK, 0, 1);
        @(negedge sample_clk);
        stuck[1] = 1'b0;
        force_realign = 2'b10;
        @(negedge sample_clk);
        force_realign = 2'b00;
        #1;
        chk("force slip_count1", int'(slip_count[15:8]), 0);
        chk("force fail1", int'(fail[1]), 0);
        wait_drain("force relock", 200);

        // Reset during SETTLE
        push(0, EV_UNLOCK, 0, 1); push(0, EV_SLIP, 1, 1);
        push(1, EV_UNLOCK, 0, 0);
        push(0, EV_SLIP, 1, 0);   push(0, EV_LOCK, 1, 0);
        push(1, EV_LOCK, 0, 0);
        @(negedge sample_clk);
        set_off(0, 2);
        force_realign = 2'b01;
        @(negedge sample_clk);
        force_realign = 2'b00;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge sample_clk);
            if (bitslip[0] === 1'b1) found = 1;
        end
        chk("settle slip seen", found, 1);
        @(negedge sample_clk);
        #1 reset_n = 1'b0;
        #1;
        chk_quiet("midsettle reset");
        chk("midsettle slip_count", int'(slip_count), 0);
        chk("midsettle loss_count", int'(loss_count), 0);
        repeat (3) @(negedge sample_clk);
        reset_n = 1'b1;
        @(negedge sample_clk); #1;
        chk("release bitslip", int'(bitslip), 0);
        wait_drain("post-reset align", 400);
        @(negedge sample_clk); #1;
        chk("post-reset slip_count0", int'(slip_count[7:0]), 1);

        // enable low and force_realign together: IDLE wins
        push(0, EV_UNLOCK, 1, 0); push(1, EV_UNLOCK, 0, 0);
        @(negedge sample_clk);
        set_off(0, 3);
        enable = 1'b0;
        force_realign = 2'b11;
        @(negedge sample_clk);
        force_realign = 2'b00;
        #1;
        chk_quiet("disable");
        repeat (15) @(negedge sample_clk); #1;
        chk("disable bitslip held", int'(bitslip), 0);
        chk("disable slip_count0 kept", int'(slip_count[7:0]), 1);
        wait_drain("disable events", 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/frame_align.md
FRAME_ALIGN -- requirements
Module: frame_align

Interface
REQ-001 SHALL have parameter N_CH, default 1: number of independent frame-clock channels, 1..8.
REQ-002 SHALL have parameter WORD_W, default 8: deserialised word width per channel.
REQ-003 SHALL have parameter PATTERN, default 8'h0F: expected frame word, WORD_W bits.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 4: wait after each bitslip before checking; minimum 2.
REQ-005 SHALL have parameter LOCK_COUNT, default 16: consecutive matches required to declare lock.
REQ-006 SHALL have parameter LOSS_COUNT, default 4: consecutive mismatches that drop lock.
REQ-007 SHALL have parameter MAX_SLIPS, default WORD_W: slips without lock before FAIL.
REQ-008 SHALL have these ports, with clock and reset listed first:
- sample_clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous reset, active-low.
- enable  in  1  level; low forces every channel to IDLE.
- force_realign  in  N_CH  per-channel one-cycle pulse that restarts alignment.
- clk_data_out  in  N_CH*WORD_W  deserialised frame word, channel c at bits [c*WORD_W +: WORD_W].
- bitslip  out  N_CH  one-cycle bitslip strobe to the channel's ISERDES.
- locked  out  N_CH  high while the channel is in LOCKED.
- fail  out  N_CH  high while the channel is in FAIL.
- slip_count  out  N_CH*8  slips since the last restart, saturating at 255.
- loss_count  out  N_CH*8  lock-loss events since reset, saturating at 255.

Function
REQ-009 Each channel SHALL have its own independent FSM with states IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL; channels share no state.
REQ-010 IDLE SHALL go to CHECK on the first cycle enable=1; slip_count is cleared on that transition.
REQ-011 CHECK SHALL compare the channel word with PATTERN every cycle.
- Match: increment the match counter; reaching LOCK_COUNT goes to LOCKED.
- Mismatch: clear the match counter and go to SLIP.
REQ-012 SLIP SHALL last exactly one cycle with bitslip[c]=1 registered, increment slip_count (saturating), then go to SETTLE.
REQ-013 SETTLE SHALL hold for exactly SETTLE_CYCLES cycles with bitslip[c]=0.
- Exit goes to FAIL if slip_count >= MAX_SLIPS, otherwise to CHECK.
REQ-014 Rising edges on bitslip[c] SHALL be at least SETTLE_CYCLES+1 cycles apart; bitslip[c] is never high for two consecutive cycles.
REQ-015 LOCKED SHALL drive locked[c]=1 and count consecutive mismatches.
- Any match clears the mismatch count.
- Reaching LOSS_COUNT increments loss_count (saturating), clears slip_count and goes to CHECK.
REQ-016 FAIL SHALL drive fail[c]=1 and hold until force_realign[c], enable low, or reset.
REQ-017 force_realign[c]=1 SHALL move channel c to CHECK from any non-IDLE state on the next cycle, clearing slip_count and the match/mismatch counters.
- A bitslip already registered in that cycle still completes.
REQ-018 Priority per cycle SHALL be: reset_n low > enable low > force_realign > normal transition.
REQ-019 locked, fail and bitslip SHALL be registered outputs decoded from the state; no output is combinational from clk_data_out.
REQ-020 With enable=0, all bitslip, locked and fail outputs SHALL be 0 on the following cycle; counters keep their values.

Reset
REQ-021 reset_n=0 SHALL asynchronously set all FSMs to IDLE, all counters to 0, and bitslip, locked and fail to 0.
REQ-022 Reset SHALL be released synchronously internally; the first state change happens no earlier than the second sample_clk edge after reset_n rises.
REQ-023 Reset asserted mid-SLIP or mid-SETTLE SHALL leave no residual bitslip pulse after release.

Verification
REQ-024 The bench SHALL use an ISERDES model that rotates the word by one bit per bitslip (N_CH=2, WORD_W=8, PATTERN=8'h0F) and cover:
- Ch0 starts rotated by 3, enable=1 -> exactly 3 bitslip pulses spaced >= 5 cycles, then locked[0]=1 after 16 matching words, slip_count[0]=3.
- Ch0 offset 1, ch1 offset 5 -> 1 and 5 slips respectively, both locked, pulses independent per channel.
- Word stuck at 8'h00 -> 8 pulses, then fail=1, bitslip stays 0; force_realign pulse -> slip_count=0 and alignment restarts.
- After lock, 3 bad words -> stays locked, loss_count=0; 4 bad words -> locked drops, loss_count=1, relocks.
- reset_n low during SETTLE -> all outputs 0 immediately; after release, realigns from IDLE with slip_count starting at 0.
- enable and force_realign asserted in the same cycle with enable=0 -> IDLE wins and no bitslip is issued.
